pc_incrementer: RTL
===================

PC_INCREMENTER -- requirements
Module: pc_incrementer

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-low.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RES  input  1  synchronous active-low reset, sampled on rising CLK.
REQ-004 DB_DATA  input  8  data bus byte, captured during reset-vector fetch.
REQ-005 ADL_DATA  input  8  address-low bus value, PCL load source.
REQ-006 ADH_DATA  input  8  address-high bus value, PCH load source.
REQ-007 ADL_LOAD  input  1  select ADL_DATA as the PCL source this cycle.
REQ-008 ADH_LOAD  input  1  select ADH_DATA as the PCH source this cycle.
REQ-009 INC  input  1  increment the PC this cycle.
REQ-010 PCL_OUT  output  8  current PCL register.
REQ-011 PCH_OUT  output  8  current PCH register.
REQ-012 ADDR  output  16  fetch address: FFFC in VEC_LO, FFFD in VEC_HI, {PCH,PCL} in RUN.
REQ-013 CARRY_PENDING  output  1  PCL wrapped; PCH increment is due next cycle.
REQ-014 VEC_ACTIVE  output  1  high in states VEC_LO and VEC_HI.

Function
REQ-015 The FSM SHALL have states VEC_LO, VEC_HI and RUN, with transitions VEC_LO->VEC_HI->RUN, one cycle each, and RUN held until reset.
REQ-016 In VEC_LO the block SHALL load PCL <= DB_DATA; in VEC_HI it SHALL load PCH <= DB_DATA.
REQ-017 In VEC_LO and VEC_HI, ADL_LOAD, ADH_LOAD and INC SHALL be ignored.
REQ-018 In RUN, the PCL source SHALL be ADL_DATA if ADL_LOAD=1, else PCL.
REQ-019 In RUN, the next PCL SHALL be (PCL source + INC) mod 256.
REQ-020 If INC=1 and the PCL source=FF, PCL SHALL become 00 and CARRY_PENDING SHALL be set for the next cycle.
REQ-021 PCH SHALL NOT change in the wrap cycle itself; the page carry is one cycle late, deliberately.
REQ-022 When CARRY_PENDING=1 and ADH_LOAD=0, the next PCH SHALL be (PCH+1) mod 256, and CARRY_PENDING SHALL clear unless a new wrap occurs in that same cycle.
REQ-023 When ADH_LOAD=1, the next PCH SHALL be ADH_DATA, and any pending carry SHALL be discarded (the jump wins).
REQ-024 When ADH_LOAD=0 and CARRY_PENDING=0, PCH SHALL hold.
REQ-025 An INC on the cycle that applies a pending carry SHALL increment PCL normally; the two updates SHALL be independent.
REQ-026 PC=FFFF with INC SHALL give PCL=00 with pending carry, then PCH=00 next cycle, so the PC wraps to 0000 with no error flag.
REQ-027 ADDR, VEC_ACTIVE and CARRY_PENDING SHALL be combinational decodes of registered state only, with no input-to-output paths.

Reset
REQ-028 While RES=0 at a rising edge, the block SHALL set state=VEC_LO, PCL=00, PCH=00 and CARRY_PENDING=0, giving VEC_ACTIVE=1 and ADDR=FFFC.
REQ-029 RES SHALL take priority over all other inputs.
REQ-030 Reset asserted mid-RUN or mid-vector SHALL abort the operation, discard any pending carry, and restart the vector fetch at VEC_LO after RES returns high.

Verification
REQ-031 Vector fetch: release RES with DB_DATA=34 in VEC_LO and 12 in VEC_HI -> ADDR shows FFFC, then FFFD, then 1234; VEC_ACTIVE falls on entering RUN.
REQ-032 Load paths: from PC=1234, ADL_DATA=AA with ADL_LOAD=1 and INC=0 -> PCL=AA. Then ADL_LOAD=1 with INC=1 and ADL_DATA=AA -> PCL=AB, PCH=12.
REQ-033 Page crossing: PC=12FF with INC for one cycle -> PC=1200 with CARRY_PENDING=1, then next cycle PC=1300 with CARRY_PENDING=0.
REQ-034 Jump overrides carry: PC=12FF with INC, then next cycle ADH_LOAD=1 with ADH_DATA=80 -> PCH=80 (not 13) and CARRY_PENDING=0.
REQ-035 Wrap and back-to-back: PC=FFFF with INC held 2 cycles -> FFFF, then FF00 (pending), then 0001.
REQ-036 Mid-operation reset: RES=0 while CARRY_PENDING=1 -> next edge PC=0000, pending=0, ADDR=FFFC; INC during VEC states leaves the PC unchanged apart from DB_DATA loads.

Source files
------------

// File: rtl/pc_incrementer_if.sv
// ---------------------------------------------------------------------------
// pc_incrementer_if
// Purpose : groups the bus-side signals of the program-counter incrementer so
//           that the block and its driver share one bundle.
// Signals :
//   db_data       [7:0]  data bus byte, captured during the reset-vector fetch
//   adl_data      [7:0]  address-low bus value, PCL load source
//   adh_data      [7:0]  address-high bus value, PCH load source
//   adl_load             select adl_data as the PCL source this cycle
//   adh_load             select adh_data as the next PCH this cycle
//   inc                  increment the PC this cycle
//   pcl_out       [7:0]  current PCL register
//   pch_out       [7:0]  current PCH register
//   addr          [15:0] fetch address (FFFC / FFFD during vector fetch)
//   carry_pending        PCL wrapped; PCH increment is due next cycle
//   vec_active           high while the reset vector is being fetched
// Modports: master drives the control/data inputs, slave is the incrementer.
// ---------------------------------------------------------------------------
interface pc_incrementer_if;
    logic [7:0]  db_data;
    logic [7:0]  adl_data;
    logic [7:0]  adh_data;
    logic        adl_load;
    logic        adh_load;
    logic        inc;
    logic [7:0]  pcl_out;
    logic [7:0]  pch_out;
    logic [15:0] addr;
    logic        carry_pending;
    logic        vec_active;

    modport master (
        output db_data, adl_data, adh_data, adl_load, adh_load, inc,
        input  pcl_out, pch_out, addr, carry_pending, vec_active
    );

    modport slave (
        input  db_data, adl_data, adh_data, adl_load, adh_load, inc,
        output pcl_out, pch_out, addr, carry_pending, vec_active
    );
endinterface

// File: rtl/pc_incrementer.sv
// ---------------------------------------------------------------------------
// pc_incrementer
// Purpose : 16-bit program counter split into PCL/PCH with a reset-vector
//           fetch (FFFC -> PCL, FFFD -> PCH) followed by a run phase in which
//           PCL can be loaded and/or incremented and PCH can be loaded or
//           receive a page carry one cycle after PCL wraps.
// Ports   :
//   i_clk    system clock, all state updates on the rising edge
//   i_res_n  synchronous active-low reset
//   bus      pc_incrementer_if.slave bundle (data/control in, PC/status out)
// ---------------------------------------------------------------------------
module pc_incrementer (
    input  logic               i_clk,
    input  logic               i_res_n,
    pc_incrementer_if.slave    bus
);

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_pcl;
    logic [7:0]  r_pch;
    logic        r_carry;

    state_t      w_nextState;
    logic [7:0]  w_nextPcl;
    logic [7:0]  w_nextPch;
    logic        w_nextCarry;
    logic [7:0]  w_pclSrc;
    logic [8:0]  w_pclSum;

    // State register. Reset wins over everything and discards any pending
    // carry, so the vector fetch always restarts cleanly at VEC_LO.
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            r_state <= VEC_LO;
            r_pcl   <= 8'h00;
            r_pch   <= 8'h00;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_pcl   <= w_nextPcl;
            r_pch   <= w_nextPch;
            r_carry <= w_nextCarry;
        end
    end

    // Next-state logic. During the vector fetch the load/increment controls
    // are ignored and only the data bus is captured. In RUN the PCL path and
    // the PCH path are independent: the PCH carry applied this cycle comes
    // from last cycle's wrap, while this cycle's wrap (bit 8 of the sum) only
    // arms the carry for the next cycle. A PCH load discards the old carry.
    always_comb begin
        w_nextState = r_state;
        w_nextPcl   = r_pcl;
        w_nextPch   = r_pch;
        w_nextCarry = 1'b0;
        w_pclSrc    = bus.adl_load ? bus.adl_data : r_pcl;
        w_pclSum    = {1'b0, w_pclSrc} + {8'h00, bus.inc};

        case (r_state)
            VEC_LO: begin
                w_nextState = VEC_HI;
                w_nextPcl   = bus.db_data;
            end
            VEC_HI: begin
                w_nextState = RUN;
                w_nextPch   = bus.db_data;
            end
            RUN: begin
                w_nextState = RUN;
                w_nextPcl   = w_pclSum[7:0];
                w_nextCarry = w_pclSum[8];
                if (bus.adh_load) begin
                    w_nextPch = bus.adh_data;
                end else if (r_carry) begin
                    w_nextPch = r_pch + 8'h01;
                end
            end
            default: begin
                w_nextState = VEC_LO;
            end
        endcase
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        bus.pcl_out       = r_pcl;
        bus.pch_out       = r_pch;
        bus.carry_pending = r_carry;
        bus.vec_active    = (r_state != RUN);
        case (r_state)
            VEC_LO:  bus.addr = 16'hFFFC;
            VEC_HI:  bus.addr = 16'hFFFD;
            default: bus.addr = {r_pch, r_pcl};
        endcase
    end

endmodule
